// File: rtl/saturate_arbiter_pkg.sv
// saturate_arbiter_pkg
// Shared helpers for the saturate arbiter. The tag type itself depends on the
// requester count, so each module builds its own tag_t from a localparam. This
// package only holds the round-robin pointer update.
package saturate_arbiter_pkg;

  // Next round-robin start point: one past the winner, wrapping at n.
  function automatic int rr_next(input int grant, input int n);
    if (grant + 1 >= n) return 0;
    else return grant + 1;
  endfunction

endpackage

// File: rtl/saturate_arbiter_tags.sv
// saturate_arbiter_tags
// Synchronous FIFO of requester tags. There is one entry for each operation
// in flight inside the saturate unit, stored in issue order.
//   clk, rst  : clock, synchronous active-high reset (empties the FIFO)
//   push      : write push_tag (ignored when full)
//   push_tag  : tag of the requester just issued
//   pop       : drop the head entry (ignored when empty)
//   head_tag  : oldest tag, i.e. owner of the next result
//   full      : DEPTH entries held
//   empty     : no entries held
module saturate_arbiter_tags #(
  parameter int DEPTH = 4,
  parameter int TAGW  = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            push,
  input  logic [TAGW-1:0] push_tag,
  input  logic            pop,
  output logic [TAGW-1:0] head_tag,
  output logic            full,
  output logic            empty
);

  localparam int AW = $clog2(DEPTH);

  // The pointers carry one extra wrap bit, so full and empty can be told
  // apart without a separate counter.
  logic [AW:0]     wr_ptr;
  logic [AW:0]     rd_ptr;
  logic [TAGW-1:0] mem [DEPTH];
  logic            do_push;
  logic            do_pop;

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head_tag = mem[rd_ptr[AW-1:0]];
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // The storage holds data only; the reset clears the pointers, not the entries.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_tag;
  end

endmodule

// File: rtl/saturate_arbiter.sv
// saturate_arbiter
// Shares one saturate unit among N requesters. Arguments are granted
// combinationally, in round-robin order by default. Once a grant has been
// offered to the saturate unit, it stays locked until the handshake completes.
// A tag FIFO records the order of the grants, so each result is routed back
// to the requester that issued it.
//
// Optional build macro: SATURATE_ARBITER_FIXED_EN selects fixed priority,
// where the lowest index wins. The round-robin pointer is then removed.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   arg_valid/arg_data/arg_ready  per-requester argument streams
//                                 (requester i data at [i*ARGW +: ARGW])
//   res_valid/res_ready           per-requester result handshake
//   res_data                      shared result bus
//   sat_arg_*                     argument stream to the saturate unit
//   sat_res_*                     result stream from the saturate unit
module saturate_arbiter #(
  parameter int N     = 4,
  parameter int ARGW  = 24,
  parameter int RESW  = 16,
  parameter int DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N-1:0]      arg_valid,
  input  logic [N*ARGW-1:0] arg_data,
  output logic [N-1:0]      arg_ready,
  output logic [N-1:0]      res_valid,
  output logic [RESW-1:0]   res_data,
  input  logic [N-1:0]      res_ready,
  output logic              sat_arg_valid,
  output logic [ARGW-1:0]   sat_arg_data,
  input  logic              sat_arg_ready,
  input  logic              sat_res_valid,
  input  logic [RESW-1:0]   sat_res_data,
  output logic              sat_res_ready
);
  import saturate_arbiter_pkg::*;

  localparam int TAGW = (N > 1) ? $clog2(N) : 1;
  typedef logic [TAGW-1:0] tag_t;

  tag_t grant;
  tag_t lock_idx;
  tag_t head_tag;
  logic lock_vld;
  logic found;
  logic full;
  logic empty;
  logic push;
  logic pop;
`ifndef SATURATE_ARBITER_FIXED_EN
  tag_t rr;
`endif

  // Picker. A locked grant overrides the scan. Otherwise the first valid
  // requester wins, scanning either from rr (round-robin) or from 0 (fixed).
  always_comb begin
    int   idx;
    tag_t sel;
    found = 1'b0;
    grant = '0;
    idx   = 0;
    sel   = '0;
    if (lock_vld) begin
      found = arg_valid[lock_idx];
      grant = lock_idx;
    end else begin
      for (int k = 0; k < N; k++) begin
`ifdef SATURATE_ARBITER_FIXED_EN
        idx = k;
`else
        idx = int'(rr) + k;
        if (idx >= N) idx = idx - N;
`endif
        sel = tag_t'(idx);
        if (!found && arg_valid[sel]) begin
          found = 1'b1;
          grant = sel;
        end
      end
    end
  end

  // Argument side. A full tag FIFO blocks issue, even in a cycle that also pops.
  always_comb begin
    sat_arg_valid = found && !full && !rst;
    sat_arg_data  = arg_data[grant*ARGW +: ARGW];
    arg_ready     = '0;
    if (sat_arg_valid) arg_ready[grant] = sat_arg_ready;
  end

  assign push = sat_arg_valid && sat_arg_ready;

  // Result side. The FIFO head selects the owner. A result that arrives while
  // the FIFO is empty is never acknowledged or routed.
  always_comb begin
    res_valid     = '0;
    res_data      = sat_res_data;
    sat_res_ready = !empty && !rst && res_ready[head_tag];
    if (sat_res_valid && !empty && !rst) res_valid[head_tag] = 1'b1;
  end

  assign pop = sat_res_valid && sat_res_ready;

  // Lock and round-robin state
  always_ff @(posedge clk) begin
    if (rst) begin
      lock_vld <= 1'b0;
      lock_idx <= '0;
`ifndef SATURATE_ARBITER_FIXED_EN
      rr       <= '0;
`endif
    end else if (push) begin
      lock_vld <= 1'b0;
`ifndef SATURATE_ARBITER_FIXED_EN
      rr       <= tag_t'(rr_next(int'(grant), N));
`endif
    end else if (sat_arg_valid) begin
      lock_vld <= 1'b1;
      lock_idx <= grant;
    end
  end

  saturate_arbiter_tags #(
    .DEPTH (DEPTH),
    .TAGW  (TAGW)
  ) u_tags (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .push_tag (grant),
    .pop      (pop),
    .head_tag (head_tag),
    .full     (full),
    .empty    (empty)
  );

endmodule
